// File: rtl/spi_cmd_pkg.sv
// Shared command-set definitions for the SPI command decoder: opcodes, lengths,
// FSM states and the opcode-to-length lookup also used by firmware tooling.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    READ_AT    = 3'b000,
    READ_NEXT  = 3'b001,
    WRITE_AT   = 3'b010,
    WRITE_NEXT = 3'b011
  } opcode_t;

  localparam logic [2:0] LEN_READ_AT    = 3'd3;
  localparam logic [2:0] LEN_READ_NEXT  = 3'd1;
  localparam logic [2:0] LEN_WRITE_AT   = 3'd4;
  localparam logic [2:0] LEN_WRITE_NEXT = 3'd2;
  localparam logic [2:0] LEN_INVALID    = 3'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Never returns 0 so the buffer always waits for at least the command byte.
  function automatic logic [2:0] cmd_length(input logic [2:0] opcode);
    logic [2:0] len;
    case (opcode)
      READ_AT:    len = LEN_READ_AT;
      READ_NEXT:  len = LEN_READ_NEXT;
      WRITE_AT:   len = LEN_WRITE_AT;
      WRITE_NEXT: len = LEN_WRITE_NEXT;
      default:    len = LEN_INVALID;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/spi_cmd_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset, for single-bit
// level signals crossing from the SPI clock domain.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_cmd.sv
// SPI command decoder: captures the buffered command on a synchronized rx_valid
// edge, issues one bus read/write, returns read data as the next tx_byte.
module spi_cmd #(
  parameter int ADDR_W = 17
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [7:0]        rx [4],
  input  logic              rx_valid,
  output logic [2:0]        length,
  output logic [7:0]        tx_byte,
  output logic              ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic              bus_ack,
  input  logic [7:0]        bus_rdata
);
  import spi_cmd_pkg::*;

  logic              vld_sync;
  logic              vld_dly_q, vld_dly_d;
  logic              vld_rise;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_q, tx_d;
  logic              ready_q, ready_d;
  logic [2:0]        op;
  logic [16:0]       at_addr;

  sync2 u_sync_valid (
    .clk   (clk_sys),
    .reset (reset),
    .d     (rx_valid),
    .q     (vld_sync)
  );

  // rx is only trusted on the capture cycle; the buffer has stopped writing by then.
  assign op       = rx[0][7:5];
  assign at_addr  = {rx[0][0], rx[1], rx[2]};
  assign length   = cmd_length(rx[0][7:5]);
  assign vld_rise = vld_sync & ~vld_dly_q;

  always_comb begin
    vld_dly_d = vld_sync;
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    unique case (state_q)
      IDLE: begin
        if (vld_rise) begin
          ready_d = 1'b0;
          if (!op[2]) begin
            state_d = REQ;
            we_d    = op[1];
            // op[0] marks the *_NEXT forms, which post-increment the last address.
            addr_d  = op[0] ? addr_q + ADDR_W'(1) : ADDR_W'(at_addr);
            if (op[1]) wdata_d = op[0] ? rx[1] : rx[3];
          end else begin
            state_d = RELEASE;
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d = RELEASE;
          if (!we_q) tx_d = bus_rdata;
        end
      end
      RELEASE: begin
        if (!vld_sync) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vld_dly_q <= 1'b0;
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      tx_q      <= '0;
      ready_q   <= 1'b1;
    end else begin
      vld_dly_q <= vld_dly_d;
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
    end
  end

  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign tx_byte   = tx_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_spi_cmd.sv
// Scoreboard bench for spi_cmd: the driver predicts bus cycles from the command
// rules, a monitor checks them as they appear, a responder plays the arbiter.
module tb_spi_cmd;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx [4];
  logic        rx_valid;
  logic [2:0]  length;
  logic [7:0]  tx_byte;
  logic        ready;
  logic        bus_req;
  logic        bus_we;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  txn_t        sb [$];
  txn_t        cur;
  logic        cur_valid = 1'b0;
  logic        prev_req  = 1'b0;
  int          ack_mode  = 0;     // 0 normal, 1 withhold, 2 hold ack high
  logic        use_fixed = 1'b0;
  logic [7:0]  fixed_rdata = 8'h00;
  logic [7:0]  last_rdata;
  int          wait_cnt = 0;
  logic [16:0] model_addr = '0;
  logic [7:0]  model_tx   = '0;
  int          len_tbl [8] = '{3, 1, 4, 2, 1, 1, 1, 1};

  always #5 clk = ~clk;

  spi_cmd #(.ADDR_W(17)) dut (
    .clk_sys   (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_valid  (rx_valid),
    .length    (length),
    .tx_byte   (tx_byte),
    .ready     (ready),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input logic val, input int budget, input string name);
    int n = 0;
    while (ready !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, ready, val);
  endtask

  // Reference: opcode rules applied to the model address/tx registers.
  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    logic [2:0] op;
    txn_t       t;
    bit         valid;
    op    = b0[7:5];
    valid = (op < 3'd4);
    wait_ready(1'b1, 60, "ready_before_cmd");
    rx[0] = 8'hFF;
    #1 check("length_invalid_byte0", length, 1);
    rx[0] = b0;
    #1 check("length", length, len_tbl[op]);
    rx[1] = b1; rx[2] = b2; rx[3] = b3;
    if (valid) begin
      t.we    = (op == 3'd2 || op == 3'd3);
      t.addr  = (op == 3'd1 || op == 3'd3) ? model_addr + 17'd1 : {b0[0], b1, b2};
      t.wdata = (op == 3'd2) ? b3 : b1;
      model_addr = t.addr;
      sb.push_back(t);
    end
    @(negedge clk);
    #2 rx_valid = 1'b1;
    wait_ready(1'b0, 10, "ready_drops_on_capture");
    repeat ($urandom_range(0, 8)) @(negedge clk);
    check("ready_low_while_valid", ready, 0);
    rx_valid = 1'b0;
    wait_ready(1'b1, 40, "ready_restores");
    if (valid && !t.we) model_tx = last_rdata;
    check("tx_byte_after_cmd", tx_byte, model_tx);
    check("addr_after_cmd", bus_addr, model_addr);
    check("bus_req_idle", bus_req, 0);
  endtask

  // Arbiter model: acks after a random number of cycles.
  initial begin
    bus_ack = 1'b0; bus_rdata = 8'h00; last_rdata = 8'h00;
    forever begin
      @(negedge clk); #1;
      if (ack_mode == 2) bus_ack = 1'b1;
      else if (bus_ack) bus_ack = 1'b0;
      else if (ack_mode == 0 && bus_req) begin
        if (wait_cnt == 0) begin
          bus_rdata  = use_fixed ? fixed_rdata : 8'($urandom);
          last_rdata = bus_rdata;
          bus_ack    = 1'b1;
          wait_cnt   = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: pops the expected cycle when bus_req rises, checks it while held.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req  = 1'b0;
        cur_valid = 1'b0;
      end else begin
        if (bus_ack && cur_valid) begin
          if (!cur.we) check("tx_byte_on_ack", tx_byte, bus_rdata);
          check("bus_req_drop_after_ack", bus_req, 0);
          cur_valid = 1'b0;
        end
        if (bus_req && !prev_req) begin
          check("sb_has_entry", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            cur       = sb.pop_front();
            cur_valid = 1'b1;
          end
        end
        if (bus_req && cur_valid) begin
          check("bus_we", bus_we, cur.we);
          check("bus_addr", bus_addr, cur.addr);
          if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
        end
        prev_req = bus_req;
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; rx_valid = 1'b0;
    rx = '{default: 8'h00};
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_tx_byte", tx_byte, 0);
    reset = 1'b0;
    @(negedge clk);

    send_cmd(8'h41, 8'h80, 8'h00, 8'h5A);
    use_fixed = 1'b1; fixed_rdata = 8'h3C;
    send_cmd(8'h00, 8'hE8, 8'h10, 8'h00);
    check("read_at_tx_3c", tx_byte, 8'h3C);
    use_fixed = 1'b0;
    send_cmd(8'h01, 8'hFF, 8'hFF, 8'h00);
    send_cmd(8'h20, 8'h00, 8'h00, 8'h00);
    check("wrap_addr_0", bus_addr, 17'h00000);
    send_cmd(8'h20, 8'h00, 8'h00, 8'h00);
    check("wrap_addr_1", bus_addr, 17'h00001);
    send_cmd(8'h40, 8'h12, 8'h34, 8'h77);
    send_cmd(8'h60, 8'hAA, 8'h00, 8'h00);
    check("write_next_addr", bus_addr, 17'h01235);
    send_cmd(8'hE0, 8'h55, 8'h66, 8'h77);

    // Reset while a read is outstanding and ack is withheld.
    ack_mode = 1;
    wait_ready(1'b1, 60, "ready_before_rst_test");
    rx[0] = 8'h00; rx[1] = 8'h22; rx[2] = 8'h44;
    sb.push_back('{we: 1'b0, addr: 17'h02244, wdata: 8'h00});
    @(negedge clk);
    #2 rx_valid = 1'b1;
    n = 0;
    while (bus_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("rst_test_req_up", bus_req, 1);
    @(negedge clk);
    #2 reset = 1'b1; rx_valid = 1'b0;
    #1;
    check("async_rst_bus_req", bus_req, 0);
    check("async_rst_ready", ready, 1);
    check("async_rst_tx_byte", tx_byte, 0);
    check("async_rst_addr", bus_addr, 0);
    model_addr = '0; model_tx = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ack_mode = 2;
    repeat (3) begin
      @(negedge clk);
      check("late_ack_no_req", bus_req, 0);
      check("late_ack_ready", ready, 1);
      check("late_ack_tx", tx_byte, 0);
    end
    ack_mode = 0;
    repeat (2) @(negedge clk);
    send_cmd(8'h00, 8'h12, 8'h34, 8'h00);

    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      send_cmd({op, 4'($urandom), 1'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
